// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding and prescaler divide rule for the stopwatch front-end
package stopwatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_LAP   = 2'd3;

  typedef enum logic [1:0] {
    SW_IDLE  = ST_IDLE,
    SW_RUN   = ST_RUN,
    SW_PAUSE = ST_PAUSE,
    SW_LAP   = ST_LAP
  } sw_state_e;

  // Number of clk cycles per count-enable pulse; callers must keep it an integer >= 2.
  function automatic int calc_div(input int clk_hz, input int tick_hz);
    return clk_hz / tick_hz;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - pushbutton synchronizer, debounce filter and press-event pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          deb;
  logic          deb_prev;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; idles at the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      deb <= 1'b1;
    end else if (sync2 == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      cnt <= '0;
      deb <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // One registered pulse on the debounced press edge; release is silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_prev <= 1'b1;
      press    <= 1'b0;
    end else begin
      deb_prev <= deb;
      press    <= deb_prev & ~deb;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch FSM, 1 Hz count-enable prescaler and counter-stage controls
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ          = 50000000,
  parameter int TICK_HZ         = 1,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_start_n,
  input  logic       key_lap_n,
  output logic       tick_en,
  output logic       clr,
  output logic       freeze,
  output logic       running,
  output logic [1:0] state
);

  localparam int            DIV       = calc_div(CLK_HZ, TICK_HZ);
  localparam int            PW        = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic          ev_s;
  logic          ev_l;
  sw_state_e     state_q;
  sw_state_e     state_d;
  logic          clr_d;
  logic          freeze_d;
  logic          running_d;
  logic [PW-1:0] presc_q;
  logic          active;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk   (clk),
    .reset (reset),
    .key_n (key_start_n),
    .press (ev_s)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lap (
    .clk   (clk),
    .reset (reset),
    .key_n (key_lap_n),
    .press (ev_l)
  );

  assign state  = state_q;
  assign active = (state_q == SW_RUN) || (state_q == SW_LAP);

  // Next state and decoded outputs; a start event always takes priority over lap.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    case (state_q)
      SW_IDLE: begin
        if (ev_s) state_d = SW_RUN;
      end
      SW_RUN: begin
        if (ev_s)      state_d = SW_PAUSE;
        else if (ev_l) state_d = SW_LAP;
      end
      SW_LAP: begin
        if (ev_s)      state_d = SW_PAUSE;
        else if (ev_l) state_d = SW_RUN;
      end
      SW_PAUSE: begin
        if (ev_s) begin
          state_d = SW_RUN;
        end else if (ev_l) begin
          state_d = SW_IDLE;
          clr_d   = 1'b1;
        end
      end
      default: state_d = SW_IDLE;
    endcase
    freeze_d  = (state_d == SW_LAP);
    running_d = (state_d == SW_RUN) || (state_d == SW_LAP);
  end

  // State register with outputs registered alongside so they align with state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SW_IDLE;
      clr     <= 1'b0;
      freeze  <= 1'b0;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      clr     <= clr_d;
      freeze  <= freeze_d;
      running <= running_d;
    end
  end

  // Prescaler: counts while timing, holds in PAUSE so the partial second survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      tick_en <= 1'b0;
    end else begin
      tick_en <= 1'b0;
      if (state_q == SW_IDLE || clr_d) begin
        presc_q <= '0;
      end else if (active) begin
        if (presc_q == PRESC_MAX) begin
          presc_q <= '0;
          tick_en <= 1'b1;
        end else begin
          presc_q <= presc_q + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl
module tb_stopwatch_ctrl;
  import stopwatch_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_start_n = 1'b1;
  logic       key_lap_n = 1'b1;
  logic       tick_en;
  logic       clr;
  logic       freeze;
  logic       running;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bad_tick = 0;
  int clr_cnt = 0;
  int tick_q[$];

  typedef struct {
    logic       s;
    logic       l;
    logic [1:0] exp_state;
    logic       exp_freeze;
    logic       exp_running;
    logic       exp_clr;
  } vec_t;

  vec_t vecs[8];
  int   exp_ticks[4];

  stopwatch_ctrl #(
    .CLK_HZ          (20),
    .TICK_HZ         (1),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_start_n (key_start_n),
    .key_lap_n   (key_lap_n),
    .tick_en     (tick_en),
    .clr         (clr),
    .freeze      (freeze),
    .running     (running),
    .state       (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Global observers sampled on the falling edge.
  always @(negedge clk) begin
    if (tick_en) tick_q.push_back(cyc);
    if (tick_en && (state == ST_IDLE || state == ST_PAUSE)) bad_tick++;
    if (tick_en && clr) bad_tick++;
    if (clr) clr_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle limit reached at cyc=%0d, required finish earlier", cyc);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int k, k0, e, x, r, prev;

    vecs[0] = '{1'b1, 1'b0, ST_RUN,   1'b0, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, ST_LAP,   1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, ST_RUN,   1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b0, ST_PAUSE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, ST_RUN,   1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b0, ST_PAUSE, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 1'b1, ST_IDLE,  1'b0, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 1'b1, ST_IDLE,  1'b0, 1'b0, 1'b0};
    exp_ticks = '{28, 48, 68, 110};

    // Reset values
    wait_until(3);
    chk("rst_state", state, ST_IDLE);
    chk("rst_tick", tick_en, 0);
    chk("rst_clr", clr, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_running", running, 0);
    reset = 1'b0;

    // Glitch shorter than the debounce window
    wait_until(6);
    k = cyc;
    key_start_n = 1'b0;
    wait_until(k + 3);
    key_start_n = 1'b1;
    wait_until(k + 25);
    #1;
    chk("glitch_state", state, ST_IDLE);
    chk("glitch_ticks", tick_q.size(), 0);

    // Table: press, check exact latency, hold, confirm single event
    wait_until(40);
    k0 = cyc;
    prev = ST_IDLE;
    for (int i = 0; i < 8; i++) begin
      k = cyc;
      key_start_n = ~vecs[i].s;
      key_lap_n   = ~vecs[i].l;
      wait_until(k + 7);
      chk($sformatf("v%0d_early_state", i), state, prev);
      wait_until(k + 8);
      chk($sformatf("v%0d_state", i), state, vecs[i].exp_state);
      chk($sformatf("v%0d_freeze", i), freeze, vecs[i].exp_freeze);
      chk($sformatf("v%0d_running", i), running, vecs[i].exp_running);
      chk($sformatf("v%0d_clr", i), clr, vecs[i].exp_clr);
      wait_until(k + 9);
      chk($sformatf("v%0d_clr_end", i), clr, 0);
      wait_until(k + 10);
      key_start_n = 1'b1;
      key_lap_n   = 1'b1;
      wait_until(k + 21);
      chk($sformatf("v%0d_hold_once", i), state, vecs[i].exp_state);
      prev = vecs[i].exp_state;
      wait_until(k + 22);
    end
    #1;
    chk("table_tick_count", tick_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < tick_q.size()) chk($sformatf("table_tick%0d", i), tick_q[i] - k0, exp_ticks[i]);
      else chk($sformatf("table_tick%0d", i), -1, exp_ticks[i]);
    end

    // After clear: START gives first tick exactly 20 cycles after entering RUN
    k = cyc;
    key_start_n = 1'b0;
    e = k + 8;
    wait_until(k + 10);
    key_start_n = 1'b1;
    wait_until(e);
    chk("a_run_state", state, ST_RUN);
    wait_until(e + 19);
    chk("a_tick_early", tick_en, 0);
    wait_until(e + 20);
    chk("a_tick_first", tick_en, 1);
    wait_until(e + 21);
    chk("a_tick_single", tick_en, 0);

    // 30 cycles of RUN then pause; resume yields tick 10 cycles later
    wait_until(e + 22);
    key_start_n = 1'b0;
    x = e + 30;
    wait_until(x);
    chk("a_pause_state", state, ST_PAUSE);
    wait_until(e + 32);
    key_start_n = 1'b1;
    wait_until(x + 20);
    key_start_n = 1'b0;
    r = x + 28;
    wait_until(x + 30);
    key_start_n = 1'b1;
    wait_until(r);
    chk("a_resume_state", state, ST_RUN);
    wait_until(r + 9);
    chk("a_resume_early", tick_en, 0);
    wait_until(r + 10);
    chk("a_resume_tick", tick_en, 1);

    // Simultaneous presses in RUN: start wins
    wait_until(r + 12);
    key_start_n = 1'b0;
    key_lap_n   = 1'b0;
    wait_until(r + 20);
    chk("b_both_state", state, ST_PAUSE);
    chk("b_both_freeze", freeze, 0);
    chk("b_both_running", running, 0);
    wait_until(r + 22);
    key_start_n = 1'b1;
    key_lap_n   = 1'b1;
    wait_until(r + 34);
    chk("b_no_lap_leftover", state, ST_PAUSE);

    // Reset during a run and during a lap debounce
    key_start_n = 1'b0;
    wait_until(r + 42);
    chk("c_run_state", state, ST_RUN);
    wait_until(r + 44);
    key_start_n = 1'b1;
    wait_until(r + 50);
    key_lap_n = 1'b0;
    wait_until(r + 54);
    reset = 1'b1;
    key_lap_n = 1'b1;
    wait_until(r + 55);
    chk("c_rst_state", state, ST_IDLE);
    chk("c_rst_tick", tick_en, 0);
    chk("c_rst_clr", clr, 0);
    chk("c_rst_freeze", freeze, 0);
    chk("c_rst_running", running, 0);
    reset = 1'b0;
    wait_until(r + 75);
    chk("c_event_lost", state, ST_IDLE);

    // Prescaler restarted from zero by reset
    key_start_n = 1'b0;
    wait_until(r + 83);
    chk("c_restart_state", state, ST_RUN);
    wait_until(r + 85);
    key_start_n = 1'b1;
    wait_until(r + 102);
    chk("c_restart_early", tick_en, 0);
    wait_until(r + 103);
    chk("c_restart_tick", tick_en, 1);

    #1;
    chk("no_tick_idle_pause_clr", bad_tick, 0);
    chk("clr_pulse_count", clr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
